// File: rtl/pixel_pkg.sv
// Shared definitions for the 4-pixel array sequencer.
//   state_e     : frame sequencer states
//   C_WIDTH_DEF : default pixel code width
//   NUM_PIX     : pixels on the array
//   max3        : helper used to size the phase counter
package pixel_pkg;

  localparam int C_WIDTH_DEF = 8;
  localparam int NUM_PIX     = 4;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ERASE       = 3'd1,
    ST_EXPOSE      = 3'd2,
    ST_CONVERT     = 3'd3,
    ST_TURN        = 3'd4,
    ST_READ_SETTLE = 3'd5,
    ST_READ_SAMPLE = 3'd6,
    ST_DONE        = 3'd7
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pixel_array_ctrl_pix_bus_driver.sv
// Tri-state driver for one pixel data bus.
//   drv_en_i : drive val_i onto the bus when high, release (Z) otherwise
//   val_i    : value to drive
//   bus_io   : the shared pixel bus
//   sample_o : whatever is currently on the bus
module pix_bus_driver #(
  parameter int W = 8
) (
  input  logic         drv_en_i,
  input  logic [W-1:0] val_i,
  inout  wire  [W-1:0] bus_io,
  output logic [W-1:0] sample_o
);

  assign bus_io   = drv_en_i ? val_i : {W{1'bz}};
  assign sample_o = bus_io;

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a 4-pixel array: erase, expose, convert (shared ramp
// count on all pixel buses), then read back each latched code over a
// valid/ready stream.
//   clk, reset           : clock and synchronous active-high reset
//   start                : begin a frame (only honoured in IDLE)
//   erase/expose/convert : array phase controls
//   read                 : one-hot per-pixel read enables
//   pix_data1..4         : bidirectional pixel buses
//   out_data/out_pix/out_valid/out_ready : read-back stream
//   busy, frame_done     : status
module pixel_array_ctrl
  import pixel_pkg::*;
#(
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255,
  parameter int C_WIDTH       = C_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               erase,
  output logic               expose,
  output logic               convert,
  output logic [3:0]         read,
  inout  wire  [C_WIDTH-1:0] pix_data1,
  inout  wire  [C_WIDTH-1:0] pix_data2,
  inout  wire  [C_WIDTH-1:0] pix_data3,
  inout  wire  [C_WIDTH-1:0] pix_data4,
  output logic [C_WIDTH-1:0] out_data,
  output logic [1:0]         out_pix,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               frame_done
);

  localparam int CNT_W = $clog2(max3(ERASE_CYCLES, EXPOSE_CYCLES, 2**C_WIDTH)) + 1;
  localparam logic [CNT_W-1:0] ERASE_LAST  = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXPOSE_LAST = CNT_W'(EXPOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'((2**C_WIDTH) - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         k_q, k_d;
  logic               erase_q, expose_q, convert_q, out_valid_q, busy_q, frame_done_q;
  logic [3:0]         read_q, read_d;
  logic [C_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]         out_pix_q, out_pix_d;
  logic [C_WIDTH-1:0] sample_s [NUM_PIX];

  // The registered convert flag doubles as the bus drive enable, so the buses
  // are released on the same edge that leaves CONVERT (TURN is the gap).
  pix_bus_driver #(.W(C_WIDTH)) u_drv1 (.drv_en_i(convert_q), .val_i(cnt_q[C_WIDTH-1:0]),
                                        .bus_io(pix_data1), .sample_o(sample_s[0]));
  pix_bus_driver #(.W(C_WIDTH)) u_drv2 (.drv_en_i(convert_q), .val_i(cnt_q[C_WIDTH-1:0]),
                                        .bus_io(pix_data2), .sample_o(sample_s[1]));
  pix_bus_driver #(.W(C_WIDTH)) u_drv3 (.drv_en_i(convert_q), .val_i(cnt_q[C_WIDTH-1:0]),
                                        .bus_io(pix_data3), .sample_o(sample_s[2]));
  pix_bus_driver #(.W(C_WIDTH)) u_drv4 (.drv_en_i(convert_q), .val_i(cnt_q[C_WIDTH-1:0]),
                                        .bus_io(pix_data4), .sample_o(sample_s[3]));

  // Next-state, phase counter and pixel index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ERASE;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERASE: begin
        if (cnt_q == ERASE_LAST) begin
          state_d = ST_EXPOSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXPOSE: begin
        if (cnt_q == EXPOSE_LAST) begin
          state_d = ST_CONVERT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CONVERT: begin
        if (cnt_q == CONV_LAST) begin
          state_d = ST_TURN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TURN: begin
        state_d = ST_READ_SETTLE;
        k_d     = 2'd0;
      end
      ST_READ_SETTLE: begin
        state_d = ST_READ_SAMPLE;
      end
      ST_READ_SAMPLE: begin
        if (out_ready && out_valid_q) begin
          if (k_q == 2'd3) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ_SETTLE;
            k_d     = k_q + 2'd1;
          end
        end else begin
          state_d = ST_READ_SAMPLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, decoded from the next state.
  always_comb begin
    out_data_d = out_data_q;
    out_pix_d  = out_pix_q;
    if ((state_d == ST_READ_SETTLE) || (state_d == ST_READ_SAMPLE)) begin
      read_d = 4'b0001 << k_d;
    end else begin
      read_d = 4'b0000;
    end
    // Capture on entry to READ_SAMPLE: the pixel has had the settle cycle to drive.
    if ((state_q == ST_READ_SETTLE) && (state_d == ST_READ_SAMPLE)) begin
      out_data_d = sample_s[k_q];
      out_pix_d  = k_q;
    end else begin
      out_data_d = out_data_q;
      out_pix_d  = out_pix_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      k_q          <= 2'd0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      read_q       <= 4'b0000;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_pix_q    <= 2'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      erase_q      <= (state_d == ST_ERASE);
      expose_q     <= (state_d == ST_EXPOSE);
      convert_q    <= (state_d == ST_CONVERT);
      read_q       <= read_d;
      out_valid_q  <= (state_d == ST_READ_SAMPLE);
      out_data_q   <= out_data_d;
      out_pix_q    <= out_pix_d;
      busy_q       <= (state_d != ST_IDLE);
      frame_done_q <= (state_d == ST_DONE);
    end
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign read       = read_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_pix    = out_pix_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Self-checking bench for pixel_array_ctrl (ERASE_CYCLES=2, EXPOSE_CYCLES=4,
// C_WIDTH=8). Model pixels latch their target code off the convert ramp and
// drive it back when their read bit is high.
module tb_pixel_array_ctrl;

  localparam int EC = 2;
  localparam int XC = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic          erase, expose, convert, out_valid, busy, frame_done;
  logic [3:0]    read;
  logic [CW-1:0] out_data;
  logic [1:0]    out_pix;
  wire  [CW-1:0] pd1, pd2, pd3, pd4;
  wire  [4*CW-1:0] pd_all = {pd4, pd3, pd2, pd1};

  logic [CW-1:0] target [4];
  logic [CW-1:0] lat    [4];
  logic          clr_lat;
  int            fd_cnt = 0;
  int            n_cmp  = 0;
  int            n_err  = 0;

  typedef struct {
    int         lo;
    int         hi;
    logic [9:0] exp; // {erase, expose, convert, read[3:0], out_valid, busy, frame_done}
  } seg_t;
  seg_t tbl [14];

  pixel_array_ctrl #(.ERASE_CYCLES(EC), .EXPOSE_CYCLES(XC), .C_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .erase(erase), .expose(expose), .convert(convert), .read(read),
    .pix_data1(pd1), .pix_data2(pd2), .pix_data3(pd3), .pix_data4(pd4),
    .out_data(out_data), .out_pix(out_pix), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign pd1 = read[0] ? lat[0] : {CW{1'bz}};
  assign pd2 = read[1] ? lat[1] : {CW{1'bz}};
  assign pd3 = read[2] ? lat[2] : {CW{1'bz}};
  assign pd4 = read[3] ? lat[3] : {CW{1'bz}};

  // Pixel comparator model: latch the ramp code when it equals the target.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (clr_lat) lat[k] <= 8'h5A;
      else if (convert && (pd_all[k*CW +: CW] == target[k])) lat[k] <= pd_all[k*CW +: CW];
    end
  end

  always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // One frame from IDLE; stall = out_ready-low cycles on pixel 1; pulse = stray starts.
  task automatic run_frame(input int stall, input bit pulse);
    int          tn;
    int          fd0;
    logic [9:0]  exp;
    logic [CW-1:0] cv;
    int          kidx;
    fd0 = fd_cnt;
    for (int n = 0; n <= 272 + stall; n++) begin
      tn  = (n <= 267) ? n : ((n <= 267 + stall) ? 267 : n - stall);
      exp = 10'd0;
      for (int s = 0; s < 14; s++) if (tn >= tbl[s].lo && tn <= tbl[s].hi) exp = tbl[s].exp;
      check($sformatf("ctl@%0d", n),
            {22'd0, erase, expose, convert, read, out_valid, busy, frame_done}, {22'd0, exp});
      if (tn >= 7 && tn <= 262) begin
        cv = CW'(tn - 7);
        if (tn % 16 == 7 || tn == 262) check($sformatf("bus@%0d", n), pd_all, {4{cv}});
      end
      if (exp[2]) begin
        kidx = (tn - 265) / 2;
        check($sformatf("pix@%0d", n), {30'd0, out_pix}, kidx);
        check($sformatf("data@%0d", n), {24'd0, out_data}, {24'd0, target[kidx]});
      end
      start     = (n == 0) || (pulse && (n == 4 || n == 265));
      out_ready = !(n >= 267 && n < 267 + stall);
      clr_lat   = (n == 0);
      @(posedge clk); #1;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    clr_lat   = 1'b0;
    check("frame_done_count", fd_cnt - fd0, 1);
  endtask

  initial begin
    tbl[0]  = '{0,   0,   10'b000_0000_0_0_0};
    tbl[1]  = '{1,   2,   10'b100_0000_0_1_0};
    tbl[2]  = '{3,   6,   10'b010_0000_0_1_0};
    tbl[3]  = '{7,   262, 10'b001_0000_0_1_0};
    tbl[4]  = '{263, 263, 10'b000_0000_0_1_0};
    tbl[5]  = '{264, 264, 10'b000_0001_0_1_0};
    tbl[6]  = '{265, 265, 10'b000_0001_1_1_0};
    tbl[7]  = '{266, 266, 10'b000_0010_0_1_0};
    tbl[8]  = '{267, 267, 10'b000_0010_1_1_0};
    tbl[9]  = '{268, 268, 10'b000_0100_0_1_0};
    tbl[10] = '{269, 269, 10'b000_0100_1_1_0};
    tbl[11] = '{270, 270, 10'b000_1000_0_1_0};
    tbl[12] = '{271, 271, 10'b000_1000_1_1_0};
    tbl[13] = '{272, 272, 10'b000_0000_0_1_1};
    target[0] = 8'd17; target[1] = 8'd200; target[2] = 8'd0; target[3] = 8'd255;

    reset = 1'b1; start = 1'b0; out_ready = 1'b1; clr_lat = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {erase, expose, convert, read, out_valid, busy, frame_done, out_data, out_pix},
          21'd0);
    reset = 1'b0; clr_lat = 1'b0;

    run_frame(0, 1'b0);   // basic frame + readback
    run_frame(0, 1'b0);   // back-to-back: start in the cycle after frame_done
    run_frame(10, 1'b0);  // backpressure on pixel 1
    run_frame(0, 1'b1);   // stray starts ignored

    // Reset during CONVERT at count 100.
    begin
      int fd0;
      fd0 = fd_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (106) @(posedge clk);
      #1;
      check("pre_reset_convert", {31'd0, convert}, 1);
      check("pre_reset_bus", {24'd0, pd1}, 100);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_reset_outputs",
            {erase, expose, convert, read, out_valid, busy, frame_done, out_data, out_pix}, 21'd0);
      repeat (3) @(posedge clk);
      #1;
      check("post_reset_idle", {30'd0, busy, convert}, 0);
      check("post_reset_no_done", fd_cnt - fd0, 0);
    end

    run_frame(0, 1'b0);   // normal frame after abort

    repeat (2) @(posedge clk);
    #1;
    check("final_idle", {29'd0, busy, frame_done, out_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
